mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width; product is 2*WIDTH.
REQ-002 The block SHALL have parameter MULT_LATENCY, default 3: latency parameter of the shared pipelined multiplier.
REQ-003 The block SHALL have parameter NREQ, default 4: number of requesters; ID_W = clog2(NREQ).
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port req_valid, input, NREQ: per-requester operand valid.
REQ-007 Port req_ready, output, NREQ: per-requester grant, one-hot or zero.
REQ-008 Port req_a / req_b, input, NREQ*WIDTH each: packed operands, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 Port flush, input, 1: level request to stop accepting work and drain.
REQ-010 Port idle, output, 1: pipeline drained and halted.
REQ-011 Port rsp_valid / rsp_id / rsp_data, output, 1 / ID_W / 2*WIDTH: result push to requesters, no backpressure.
REQ-012 Port mult_enable / mult_dataa / mult_datab, output, 1 / WIDTH / WIDTH: drive the shared multiplier.
REQ-013 Port mult_res, input, 2*WIDTH: multiplier product.

Function
REQ-014 Transfer from requester i SHALL occur in a cycle with req_valid[i]=1 and req_ready[i]=1; at most one transfer per cycle.
REQ-015 req_ready SHALL be combinational: one-hot on the round-robin winner among asserted req_valid bits when state=RUN and flush=0, else all zero.
REQ-016 Round-robin: priority SHALL start at last_grant+1 modulo NREQ; last_grant updates only on a transfer; reset value NREQ-1, so requester 0 wins first.
REQ-017 mult_dataa/mult_datab SHALL equal the winner's req_a/req_b combinationally in a transfer cycle, and 0 otherwise.
REQ-018 mult_enable SHALL be a register: 0 in reset, 1 from the first clock edge after reset release, and constant thereafter.
REQ-019 A tag shift register of depth PIPE = MULT_LATENCY+2 (valid bit + ID_W id) SHALL advance every cycle; stage 0 loads {transfer, winner id}.
REQ-020 A transfer in cycle t SHALL produce rsp_valid=1 in cycle t+PIPE, with rsp_id = that requester's id and rsp_data = mult_res combinationally.
REQ-021 rsp_data SHALL be 0 whenever rsp_valid=0.
REQ-022 Back-to-back transfers SHALL yield back-to-back responses in issue order, with no bubbles inserted.
REQ-023 The state machine SHALL have states RUN, DRAIN and HALTED.
REQ-024 RUN SHALL move to DRAIN when flush=1; flush gates grants in the same cycle it is seen.
REQ-025 DRAIN SHALL move to HALTED when all tag valid bits are 0, and SHALL move to RUN when flush=0 (flush=0 takes precedence).
REQ-026 HALTED SHALL move to RUN when flush=0.
REQ-027 idle SHALL equal (state==HALTED).
REQ-028 In-flight tags SHALL complete and respond in DRAIN; flush never drops results.
REQ-029 A requester deasserting req_valid before grant SHALL be legal; no state is held for it.

Reset
REQ-030 On reset, regardless of clock: state=RUN, last_grant=NREQ-1, all tag valid bits 0, mult_enable=0.
REQ-031 In reset, outputs req_ready, rsp_valid, rsp_id, rsp_data and idle SHALL all be 0.
REQ-032 Reset mid-operation SHALL discard all in-flight tags; stale multiplier outputs SHALL never raise rsp_valid after release.

Structure
REQ-033 A shared package mult_pkg SHALL hold WIDTH, MULT_LATENCY, NREQ, PIPE, ID_W and the state encoding.
REQ-034 Round-robin selection SHALL be one sub-module rr_arbiter (inputs: request vector and last_grant; outputs: one-hot grant and winner id).
REQ-035 The multiplier SHALL be instantiated outside this block.

Verification (WIDTH=8, MULT_LATENCY=3, NREQ=4, PIPE=5)
REQ-036 Single request: req 2 sends a=0x0F, b=0x11, transfer in cycle t -> cycle t+5 shows rsp_valid=1, rsp_id=2, rsp_data=0x00FF; no other rsp_valid.
REQ-037 All four req_valid held for 8 cycles -> grant order 0,1,2,3,0,1,2,3 -> responses in cycles t+5..t+12 in the same id order.
REQ-038 Boundary operands: a=0xFF, b=0xFF -> rsp_data=0xFE01; a=0x00, b=0xFF -> rsp_data=0x0000.
REQ-039 Flush with 3 transfers in flight -> req_ready=0 from the flush cycle -> 3 responses arrive -> idle=1 the cycle after the last tag clears -> flush=0 -> grants resume at the next round-robin requester.
REQ-040 Reset pulse with 2 transfers in flight -> all outputs 0 immediately -> no rsp_valid for 10 cycles after release -> first grant goes to requester 0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared configuration and state encoding for the multiplier arbiter.
package mult_pkg;

  localparam int unsigned WIDTH        = 8;
  localparam int unsigned MULT_LATENCY = 3;
  localparam int unsigned NREQ         = 4;
  localparam int unsigned PIPE         = MULT_LATENCY + 2;
  localparam int unsigned ID_W         = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: priority starts one past the last granted requester.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned NREQ = mult_pkg::NREQ,
  parameter int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] id_o
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    cand  = '0;
    // Walk last+1 .. last+NREQ so the previous winner is considered last.
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = ID_W'((32'(last_i) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        id_o        = cand;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one pipelined multiplier among NREQ requesters,
// with a tag pipeline that routes each product back and a flush/drain handshake.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH        = mult_pkg::WIDTH,
  parameter int unsigned MULT_LATENCY = mult_pkg::MULT_LATENCY,
  parameter int unsigned NREQ         = mult_pkg::NREQ,
  localparam int unsigned ID_W        = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned PIPE        = MULT_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic                  flush,
  output logic                  idle,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic                  mult_enable,
  output logic [WIDTH-1:0]      mult_dataa,
  output logic [WIDTH-1:0]      mult_datab,
  input  logic [2*WIDTH-1:0]    mult_res
);

  state_e                    state_q, state_d;
  logic [ID_W-1:0]           last_grant_q;
  logic [PIPE-1:0]           tag_vld_q;
  logic [PIPE-1:0][ID_W-1:0] tag_id_q;
  logic                      mult_enable_q;

  logic [NREQ-1:0] rr_gnt;
  logic [ID_W-1:0] win_id;
  logic            transfer;

  rr_arbiter #(
    .NREQ(NREQ),
    .ID_W(ID_W)
  ) u_rr (
    .req_i (req_valid),
    .last_i(last_grant_q),
    .gnt_o (rr_gnt),
    .id_o  (win_id)
  );

  // Reset gates grants directly since state_q reads RUN while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == StRun && !flush && !reset) req_ready = rr_gnt;
  end

  assign transfer = |req_ready;

  always_comb begin
    mult_dataa = '0;
    mult_datab = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_ready[i]) begin
        mult_dataa = req_a[i*WIDTH +: WIDTH];
        mult_datab = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (flush) state_d = StDrain;
      StDrain: begin
        if (!flush)               state_d = StRun;
        else if (tag_vld_q == '0) state_d = StHalted;
      end
      StHalted: if (!flush) state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      last_grant_q  <= ID_W'(NREQ - 1);
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      mult_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (transfer) last_grant_q <= win_id;
      tag_vld_q     <= {tag_vld_q[PIPE-2:0], transfer};
      tag_id_q      <= {tag_id_q[PIPE-2:0], win_id};
      mult_enable_q <= 1'b1;
    end
  end

  assign rsp_valid   = tag_vld_q[PIPE-1];
  assign rsp_id      = rsp_valid ? tag_id_q[PIPE-1] : '0;
  assign rsp_data    = rsp_valid ? mult_res : '0;
  assign idle        = (state_q == StHalted);
  assign mult_enable = mult_enable_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: stimulus pushes expected responses, a monitor pops and checks.
module tb_mult_arbiter;

  localparam int PIPE = 5;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        idle;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        mult_enable;
  logic [7:0]  mult_dataa;
  logic [7:0]  mult_datab;
  logic [15:0] mult_res;

  mult_arbiter #(
    .WIDTH(8),
    .MULT_LATENCY(3),
    .NREQ(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .idle       (idle),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .mult_enable(mult_enable),
    .mult_dataa (mult_dataa),
    .mult_datab (mult_datab),
    .mult_res   (mult_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier model: operands of cycle t appear on mult_res in cycle t+PIPE.
  logic [15:0] mpipe [PIPE];
  always @(posedge clk) begin
    if (mult_enable) begin
      mpipe[0] <= mult_dataa * mult_datab;
      for (int k = 1; k < PIPE; k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign mult_res = mpipe[PIPE-1];

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data 0x%0h, required no response (cycle %0d)",
                 rsp_id, rsp_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        check("rsp_cycle", cyc, mon_e.cyc);
      end
    end else begin
      check("rsp_data_idle", 32'(rsp_data), 32'h0);
    end
  end

  // One clock cycle of stimulus; checks the grant and records the expected response.
  task automatic step(input logic [3:0] vld, input logic fl, input logic [3:0] exp_rdy,
                      input logic [15:0] exp_data, input logic exp_idle, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = vld;
    flush     = fl;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("idle", 32'(idle), 32'(exp_idle));
    if (exp_rdy == 4'b0000) check("mult_operands_zero", {16'h0, mult_dataa, mult_datab}, 32'h0);
    if (push && exp_rdy != 4'b0000) begin
      e.id = 2'd0;
      for (int k = 0; k < 4; k++) if (exp_rdy[k]) e.id = 2'(k);
      e.data = exp_data;
      e.cyc  = cyc + PIPE;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(4'b0000, 1'b0, 4'b0000, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    flush     = 1'b0;
    // Requesters 0..3: 3*5, 0x10*0x10, 0x7F*2, 0xFF*0xFF
    req_a     = {8'hFF, 8'h7F, 8'h10, 8'h03};
    req_b     = {8'hFF, 8'h02, 8'h10, 8'h05};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_idle", 32'(idle), 32'h0);
    check("reset_mult_enable", 32'(mult_enable), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mult_enable_after_release", 32'(mult_enable), 32'h1);

    // All four requesting for 8 cycles: strict 0,1,2,3 rotation.
    for (int r = 0; r < 2; r++) begin
      step(4'b1111, 1'b0, 4'b0001, 16'h000F, 1'b0, 1'b1);
      step(4'b1111, 1'b0, 4'b0010, 16'h0100, 1'b0, 1'b1);
      step(4'b1111, 1'b0, 4'b0100, 16'h00FE, 1'b0, 1'b1);
      step(4'b1111, 1'b0, 4'b1000, 16'hFE01, 1'b0, 1'b1);
    end
    idle_steps(8);

    // Single request from requester 2: 0x0F * 0x11 = 0x00FF.
    req_a[23:16] = 8'h0F;
    req_b[23:16] = 8'h11;
    step(4'b0100, 1'b0, 4'b0100, 16'h00FF, 1'b0, 1'b1);
    idle_steps(7);

    // Zero operand on requester 1, then priority wrap with sparse requests.
    req_a[15:8] = 8'h00;
    req_b[15:8] = 8'hFF;
    step(4'b0010, 1'b0, 4'b0010, 16'h0000, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 4'b0100, 16'h00FF, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 4'b0001, 16'h000F, 1'b0, 1'b1);
    idle_steps(6);

    // Flush with three transfers in flight.
    step(4'b1111, 1'b0, 4'b0010, 16'h0000, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 4'b0100, 16'h00FF, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 4'b1000, 16'hFE01, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(4'b1111, 1'b1, 4'b0000, 16'h0, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 4'b0000, 16'h0, 1'b1, 1'b1);
    check("flush_all_responded", exp_q.size(), 0);
    step(4'b1111, 1'b0, 4'b0000, 16'h0, 1'b1, 1'b1);
    step(4'b1111, 1'b0, 4'b0001, 16'h000F, 1'b0, 1'b1);
    idle_steps(6);

    // Reset with two transfers in flight: their results must never appear.
    step(4'b1111, 1'b0, 4'b0010, 16'h0000, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 4'b0100, 16'h00FF, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midreset_req_ready", 32'(req_ready), 32'h0);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midreset_rsp_id", 32'(rsp_id), 32'h0);
    check("midreset_rsp_data", 32'(rsp_data), 32'h0);
    check("midreset_idle", 32'(idle), 32'h0);
    check("midreset_mult_dataa", 32'(mult_dataa), 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 4'b0000;
    idle_steps(10);
    step(4'b1111, 1'b0, 4'b0001, 16'h000F, 1'b0, 1'b1);
    idle_steps(8);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
